// File: rtl/lc2k_ctrl_fsm.sv
// lc2k_ctrl_fsm: multicycle control FSM for the LC2K core.
// Steps one instruction at a time through fetch, decode, execute and then
// memory and/or writeback, driving the shared ALU, the PC/IR/ALUOUT/MDR
// latches, the register file and a single-ported memory.
// Optional macro LC2K_PERF_CNT_EN adds cycle_cnt / instr_cnt counters.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module lc2k_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [`DATA_LEN-1:0] instr,
    input  logic                 alu_eq,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_we,
    output logic                 mdr_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 alu_op,
    output logic [1:0]           alu_a_sel,
    output logic [1:0]           alu_b_sel,
    output logic                 aluout_we,
    output logic                 reg_we,
    output logic                 reg_wr_sel,
    output logic [1:0]           reg_data_sel,
    output logic                 halted,
    output logic [3:0]           state_dbg
`ifdef LC2K_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instr_cnt
`endif
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_BEQ1   = 4'd6,
        S_BEQ2   = 4'd7,
        S_BEQ3   = 4'd8,
        S_HALT   = 4'd9
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_JALR = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    state_e     state_q, state_d;
    logic [2:0] opc;

    // Only the opcode field steers control; the rest of IR feeds the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[`DATA_LEN-1:25], instr[21:0]};

    assign opc       = instr[24:22];
    assign state_dbg = state_q;

    // Next-state and strobe decode from current state and opcode.
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        alu_op       = 1'b0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 2'd0;
        aluout_we    = 1'b0;
        reg_we       = 1'b0;
        reg_wr_sel   = 1'b0;
        reg_data_sel = 2'd0;
        halted       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                // Request held at PC until memory accepts; IR and PC+1 load together.
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opc)
                    OP_ADD, OP_NOR, OP_LW, OP_SW: state_d = S_EXEC;
                    OP_BEQ:                       state_d = S_BEQ1;
                    OP_JALR:                      state_d = S_WB;
                    OP_HALT:                      state_d = S_HALT;
                    default:                      state_d = S_FETCH;
                endcase
            end
            S_EXEC: begin
                aluout_we = 1'b1;
                case (opc)
                    OP_ADD: state_d = S_WB;
                    OP_NOR: begin
                        alu_op  = 1'b1;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_b_sel = 2'd1;
                        state_d   = S_MEM;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opc == OP_SW);
                if (mem_ready) begin
                    if (opc == OP_SW) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
                case (opc)
                    OP_LW: begin
                        reg_wr_sel   = 1'b1;
                        reg_data_sel = 2'd1;
                    end
                    OP_JALR: begin
                        // PC already holds PC+1; regA is read before this write lands.
                        reg_wr_sel   = 1'b1;
                        reg_data_sel = 2'd2;
                        pc_we        = 1'b1;
                        pc_sel       = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_BEQ1: begin
                // ALUOUT = ~regB (nor of regB with itself).
                alu_a_sel = 2'd2;
                alu_op    = 1'b1;
                aluout_we = 1'b1;
                state_d   = S_BEQ2;
            end
            S_BEQ2: begin
                // ALUOUT = ~regB + 1 = -regB.
                alu_a_sel = 2'd1;
                alu_b_sel = 2'd2;
                aluout_we = 1'b1;
                state_d   = S_BEQ3;
            end
            S_BEQ3: begin
                // regA + (-regB) is zero exactly when the operands match.
                alu_b_sel = 2'd3;
                if (alu_eq) begin
                    pc_we  = 1'b1;
                    pc_sel = 2'd1;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; async reset returns to IDLE, dropping every strobe at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

`ifdef LC2K_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // Cycles count while busy; instructions retire on re-entry to FETCH or HALT.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != S_IDLE && state_q != S_HALT)
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if ((state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE) ||
            (state_d == S_HALT && state_q != S_HALT))
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: doc/lc2k_ctrl_fsm.md
Name: lc2k_ctrl_fsm

Overview:
- Multicycle control FSM for the LC2K core. Sequences the shared single ALU (op 0 = add, 1 = nor; eq flag = result==0), the PC, IR, ALUOUT and MDR latches, the register file and a single-ported memory.
- One instruction at a time: fetch, decode, execute, then memory and/or writeback.
- beq is done on the ALU alone as a 3-step two's-complement subtract.

Parameters:
- CNT_W, 32, width of the performance counters (used only when LC2K_PERF_CNT_EN is defined).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; leaves IDLE
- instr  in  `DATA_LEN  current IR contents; opcode = instr[24:22]
- alu_eq  in  1  ALU eq flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write (sw)
- mem_addr_sel  out  1  0 = PC, 1 = ALUOUT
- ir_we  out  1  load IR from memory read data
- mdr_we  out  1  load MDR from memory read data
- pc_we  out  1  load PC
- pc_sel  out  2  0 = PC+1, 1 = PC+sext(offset), 2 = regA value
- alu_op  out  1  0 = add, 1 = nor
- alu_a_sel  out  2  0 = regA, 1 = ALUOUT, 2 = regB
- alu_b_sel  out  2  0 = regB, 1 = sext(instr[15:0]), 2 = constant 1, 3 = ALUOUT
- aluout_we  out  1  latch ALU result
- reg_we  out  1  register file write
- reg_wr_sel  out  1  0 = destReg instr[2:0], 1 = regB instr[18:16]
- reg_data_sel  out  2  0 = ALUOUT, 1 = MDR, 2 = PC
- halted  out  1  sticky halt indication
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: asynchronous on reset_n low.
  - State goes to IDLE and every output is 0, including mem_req, which drops in the same cycle even mid-request.
  - On reset release, the FSM stays in IDLE until start.
- Outputs decode combinationally from state and opcode; any output not named for a state below is 0.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BEQ1=6, BEQ2=7, BEQ3=8, HALT=9.
- IDLE: start=1 -> FETCH. start is ignored in every other state.
- FETCH:
  - Outputs: mem_req=1, mem_we=0, mem_addr_sel=0.
  - Hold all request outputs stable until mem_ready.
  - On mem_ready: ir_we=1, pc_we=1, pc_sel=0 -> DECODE.
- DECODE: one cycle, no strobes. Next state by opcode:
  - 0 add, 1 nor, 2 lw, 3 sw -> EXEC
  - 4 beq -> BEQ1
  - 5 jalr -> WB
  - 6 halt -> HALT
  - 7 noop -> FETCH
- EXEC: aluout_we=1, alu_a_sel=0.
  - add: alu_op=0, alu_b_sel=0 -> WB.
  - nor: alu_op=1, alu_b_sel=0 -> WB.
  - lw/sw: alu_op=0, alu_b_sel=1 -> MEM.
- MEM: mem_req=1, mem_addr_sel=1, mem_we = (opcode==sw). Hold until mem_ready.
  - lw: on mem_ready, mdr_we=1 -> WB.
  - sw: on mem_ready -> FETCH.
- WB: reg_we=1 for one cycle, then -> FETCH.
  - add/nor: reg_wr_sel=0, reg_data_sel=0.
  - lw: reg_wr_sel=1, reg_data_sel=1.
  - jalr: reg_wr_sel=1, reg_data_sel=2 (PC already incremented), plus pc_we=1, pc_sel=2. The register file write and PC load happen on the same edge; the regA value is read before the write, so regA==regB yields PC = old regA.
- beq (ALUOUT = -regB, then regA + ALUOUT):
  - BEQ1: alu_a_sel=2, alu_b_sel=0, alu_op=1, aluout_we=1 (ALUOUT = ~regB).
  - BEQ2: alu_a_sel=1, alu_b_sel=2, alu_op=0, aluout_we=1 (ALUOUT = -regB).
  - BEQ3: alu_a_sel=0, alu_b_sel=3, alu_op=0; if alu_eq then pc_we=1, pc_sel=1. Always -> FETCH.
  - Width rule: all arithmetic wraps modulo 2^`DATA_LEN. regB=0 gives -0=0 and the compare stays correct.
- HALT: halted=1, no other strobes. Terminal; only reset_n exits.
- mem_ready sampled in any state other than FETCH/MEM is ignored. mem_ready in the first cycle of a request is legal, giving zero wait states.

Optional Feature:
- Macro: LC2K_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt [CNT_W-1:0] and instr_cnt [CNT_W-1:0], both reset to 0.
  - cycle_cnt increments every cycle the state is not IDLE or HALT.
  - instr_cnt increments on every transition into FETCH from a non-IDLE state, and on entry to HALT.
  - Both counters wrap at 2^CNT_W and freeze in HALT.
- Undefined: the ports do not exist and no counter logic is built.

Test Plan:
- Reset then start, fetch with mem_ready after 3 wait cycles, IR=noop -> mem_req high for exactly 4 cycles with stable address select; ir_we and pc_we pulse once; state path FETCH, DECODE, FETCH.
- add 1 2 3 with zero-wait memory -> 4 cycles FETCH..WB; in WB, reg_we=1, reg_wr_sel=0, reg_data_sel=0; next is FETCH.
- beq with regA=5, regB=5 -> BEQ3 sees alu_eq=1, pc_we=1, pc_sel=1. Repeat with regA=5, regB=6 -> pc_we=0 in BEQ3.
- lw (2-cycle memory), then sw -> lw path ends with MEM mdr_we and WB reg_wr_sel=1, reg_data_sel=1; sw has mem_we=1 and no WB state.
- reset_n low during MEM with mem_req=1 -> mem_req=0 in the same cycle and state_dbg=0; start after release refetches.
- halt -> halted=1 held for 100 cycles and start ignored; with LC2K_PERF_CNT_EN defined, program noop, add, halt gives instr_cnt=3 and cycle_cnt frozen.
